// File: rtl/mem_stage_if.sv
// Signal bundle between the memory stage, its pipeline neighbours and the data bus.
// The "master" view belongs to the stage itself, and the "slave" view belongs to
// whatever surrounds it (the upstream/downstream stages and the memory system).
interface mem_stage_if;
  // Stage handshake.
  logic        ena;
  logic        ack;
  logic        req;

  // Operands from execute.
  logic [7:0]  i_inst_opcode;
  logic [63:0] i_addr;
  logic [63:0] i_wdata;
  logic [63:0] i_rd_wdata;

  // Data bus.
  logic        o_mem_valid;
  logic        i_mem_ready;
  logic [63:0] o_mem_addr;
  logic        o_mem_wen;
  logic [63:0] o_mem_wdata;
  logic [7:0]  o_mem_wstrb;
  logic        i_mem_resp;
  logic [63:0] i_mem_rdata;

  // Write-back result.
  logic [63:0] o_rd_wdata;
  logic        o_misalign;

  modport master (
    input  ena, ack, i_inst_opcode, i_addr, i_wdata, i_rd_wdata,
    input  i_mem_ready, i_mem_resp, i_mem_rdata,
    output req, o_mem_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wstrb,
    output o_rd_wdata, o_misalign
  );

  modport slave (
    output ena, ack, i_inst_opcode, i_addr, i_wdata, i_rd_wdata,
    output i_mem_ready, i_mem_resp, i_mem_rdata,
    input  req, o_mem_valid, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wstrb,
    input  o_rd_wdata, o_misalign
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the execute result and load/store operands,
// performs at most one aligned 64-bit bus transaction with byte-lane steering, and
// hands the final write-back value downstream over the ena/req/ack handshake.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.master bus
);

  // Opcode encodings, kept in step with the INST_* values of defines.v.
  localparam logic [7:0] INST_LB  = 8'h20;
  localparam logic [7:0] INST_LH  = 8'h21;
  localparam logic [7:0] INST_LW  = 8'h22;
  localparam logic [7:0] INST_LD  = 8'h23;
  localparam logic [7:0] INST_LBU = 8'h24;
  localparam logic [7:0] INST_LHU = 8'h25;
  localparam logic [7:0] INST_LWU = 8'h26;
  localparam logic [7:0] INST_SB  = 8'h28;
  localparam logic [7:0] INST_SH  = 8'h29;
  localparam logic [7:0] INST_SW  = 8'h2A;
  localparam logic [7:0] INST_SD  = 8'h2B;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUS_REQ  = 2'd1,
    BUS_RESP = 2'd2,
    DONE     = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  opcode_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] result_q;
  logic        misalign_q;

  function automatic logic isLoad(input logic [7:0] op);
    return (op == INST_LB) || (op == INST_LH) || (op == INST_LW) || (op == INST_LD) ||
           (op == INST_LBU) || (op == INST_LHU) || (op == INST_LWU);
  endfunction

  function automatic logic isStore(input logic [7:0] op);
    return (op == INST_SB) || (op == INST_SH) || (op == INST_SW) || (op == INST_SD);
  endfunction

  // Access size as log2(bytes); non-memory opcodes fall into the byte bucket,
  // which is harmless because they never reach the bus.
  function automatic logic [1:0] sizeLog2(input logic [7:0] op);
    logic [1:0] s;
    s = 2'd0;
    case (op)
      INST_LH, INST_LHU, INST_SH: s = 2'd1;
      INST_LW, INST_LWU, INST_SW: s = 2'd2;
      INST_LD, INST_SD:           s = 2'd3;
      default:                    s = 2'd0;
    endcase
    return s;
  endfunction

  function automatic logic isMisaligned(input logic [7:0] op, input logic [2:0] a);
    logic m;
    m = 1'b0;
    case (sizeLog2(op))
      2'd1:    m = a[0];
      2'd2:    m = |a[1:0];
      2'd3:    m = |a;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  logic        inMem;
  logic        inMis;
  logic [2:0]  off;
  logic [5:0]  shamt;
  logic [63:0] laneData;
  logic [63:0] loadValue;
  logic [7:0]  strbBase;

  // Classification of the incoming operands, only used on the start edge.
  assign inMem = isLoad(bus.i_inst_opcode) || isStore(bus.i_inst_opcode);
  assign inMis = inMem && isMisaligned(bus.i_inst_opcode, bus.i_addr[2:0]);

  assign off      = addr_q[2:0];
  assign shamt    = {off, 3'b000};
  assign laneData = bus.i_mem_rdata >> shamt;

  // Pick the addressed field out of the read doubleword and extend it to 64 bits.
  always_comb begin
    loadValue = laneData;
    case (opcode_q)
      INST_LB:  loadValue = {{56{laneData[7]}},  laneData[7:0]};
      INST_LH:  loadValue = {{48{laneData[15]}}, laneData[15:0]};
      INST_LW:  loadValue = {{32{laneData[31]}}, laneData[31:0]};
      INST_LBU: loadValue = {56'd0, laneData[7:0]};
      INST_LHU: loadValue = {48'd0, laneData[15:0]};
      INST_LWU: loadValue = {32'd0, laneData[31:0]};
      default:  loadValue = laneData;
    endcase
  end

  // Unshifted byte-enable pattern for the latched access size.
  always_comb begin
    strbBase = 8'h01;
    case (sizeLog2(opcode_q))
      2'd1:    strbBase = 8'h03;
      2'd2:    strbBase = 8'h0F;
      2'd3:    strbBase = 8'hFF;
      default: strbBase = 8'h01;
    endcase
  end

  // State register; reset drops straight back to IDLE from any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; ena only matters in IDLE, resp only in BUS_RESP, ack only in DONE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.ena) begin
          if (inMem && !inMis) begin
            state_d = BUS_REQ;
          end else begin
            state_d = DONE;
          end
        end
      end
      BUS_REQ: begin
        if (bus.i_mem_ready) begin
          state_d = BUS_RESP;
        end
      end
      BUS_RESP: begin
        if (bus.i_mem_resp) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.ack) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Operand capture on start, and load data capture on the response edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcode_q   <= 8'd0;
      addr_q     <= 64'd0;
      wdata_q    <= 64'd0;
      result_q   <= 64'd0;
      misalign_q <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.ena) begin
        opcode_q   <= bus.i_inst_opcode;
        addr_q     <= bus.i_addr;
        wdata_q    <= bus.i_wdata;
        result_q   <= bus.i_rd_wdata;
        misalign_q <= inMis;
      end else if (state_q == BUS_RESP && bus.i_mem_resp && isLoad(opcode_q)) begin
        result_q <= loadValue;
      end
    end
  end

  logic        reqOut;
  logic        memValidOut;
  logic [63:0] memAddrOut;
  logic        memWenOut;
  logic [63:0] memWdataOut;
  logic [7:0]  memWstrbOut;
  logic        misalignOut;

  // Outputs decoded from registered state only; bus fields are driven while the request is up.
  always_comb begin
    reqOut      = 1'b0;
    memValidOut = 1'b0;
    memAddrOut  = 64'd0;
    memWenOut   = 1'b0;
    memWdataOut = 64'd0;
    memWstrbOut = 8'd0;
    misalignOut = 1'b0;
    case (state_q)
      BUS_REQ: begin
        memValidOut = 1'b1;
        memAddrOut  = {addr_q[63:3], 3'b000};
        memWenOut   = isStore(opcode_q);
        memWdataOut = wdata_q << shamt;
        memWstrbOut = isStore(opcode_q) ? (strbBase << off) : 8'd0;
      end
      DONE: begin
        reqOut      = 1'b1;
        misalignOut = misalign_q;
      end
      default: begin
      end
    endcase
  end

  assign bus.req         = reqOut;
  assign bus.o_mem_valid = memValidOut;
  assign bus.o_mem_addr  = memAddrOut;
  assign bus.o_mem_wen   = memWenOut;
  assign bus.o_mem_wdata = memWdataOut;
  assign bus.o_mem_wstrb = memWstrbOut;
  assign bus.o_rd_wdata  = result_q;
  assign bus.o_misalign  = misalignOut;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: drives the stage and a simple bus responder,
// predicts results with its own model, and checks them through a scoreboard.
module tb_mem_stage;

  localparam logic [7:0] INST_ADD = 8'h01;
  localparam logic [7:0] INST_LB  = 8'h20;
  localparam logic [7:0] INST_LH  = 8'h21;
  localparam logic [7:0] INST_LW  = 8'h22;
  localparam logic [7:0] INST_LD  = 8'h23;
  localparam logic [7:0] INST_LBU = 8'h24;
  localparam logic [7:0] INST_LHU = 8'h25;
  localparam logic [7:0] INST_LWU = 8'h26;
  localparam logic [7:0] INST_SB  = 8'h28;
  localparam logic [7:0] INST_SH  = 8'h29;
  localparam logic [7:0] INST_SW  = 8'h2A;
  localparam logic [7:0] INST_SD  = 8'h2B;

  typedef struct {
    logic [63:0] res;
    logic        mis;
  } expect_t;

  logic clk;
  logic rst;
  int   nChecks;
  int   nFail;
  expect_t sb[$];

  mem_stage_if tbIf();

  mem_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (tbIf)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scrambleInputs();
    tbIf.i_inst_opcode = 8'($urandom);
    tbIf.i_addr        = {$urandom, $urandom};
    tbIf.i_wdata       = {$urandom, $urandom};
    tbIf.i_rd_wdata    = {$urandom, $urandom};
  endtask

  // Reference model of one access, written byte by byte.
  function automatic void modelAccess(input logic [7:0] op, input logic [63:0] addr,
                                      input logic [63:0] wdata, input logic [63:0] rdw,
                                      input logic [63:0] rdata, output expect_t e,
                                      output logic [7:0] strb, output logic [63:0] wd,
                                      output bit mem, output bit mis, output bit st);
    int size;
    int off;
    bit ld;
    bit sgn;
    logic [63:0] val;
    size = 1; ld = 0; st = 0; sgn = 0;
    case (op)
      INST_LB:  begin size = 1; ld = 1; sgn = 1; end
      INST_LH:  begin size = 2; ld = 1; sgn = 1; end
      INST_LW:  begin size = 4; ld = 1; sgn = 1; end
      INST_LD:  begin size = 8; ld = 1; end
      INST_LBU: begin size = 1; ld = 1; end
      INST_LHU: begin size = 2; ld = 1; end
      INST_LWU: begin size = 4; ld = 1; end
      INST_SB:  begin size = 1; st = 1; end
      INST_SH:  begin size = 2; st = 1; end
      INST_SW:  begin size = 4; st = 1; end
      INST_SD:  begin size = 8; st = 1; end
      default:  begin size = 1; end
    endcase
    mem  = ld || st;
    mis  = mem && ((addr % size) != 0);
    off  = int'(addr % 8);
    strb = 8'd0;
    if (st && !mis) begin
      for (int i = 0; i < size; i++) strb[off + i] = 1'b1;
    end
    wd = 64'd0;
    for (int i = 0; i + off < 8; i++) wd[8*(i + off) +: 8] = wdata[8*i +: 8];
    e.res = rdw;
    e.mis = mis;
    if (ld && !mis) begin
      val = 64'd0;
      for (int i = 0; i < size; i++) val[8*i +: 8] = rdata[8*(off + i) +: 8];
      if (sgn && val[8*size - 1]) begin
        for (int i = size; i < 8; i++) val[8*i +: 8] = 8'hFF;
      end
      e.res = val;
    end
  endfunction

  // One complete transaction: start, optional bus phase, result check and ack.
  task automatic applyStimulus(input logic [7:0] op, input logic [63:0] addr,
                               input logic [63:0] wdata, input logic [63:0] rdw,
                               input logic [63:0] rdata, input int readyWait,
                               input int respWait, input int ackWait);
    expect_t     e;
    expect_t     got;
    logic [7:0]  expStrb;
    logic [63:0] expWdata;
    bit          mem;
    bit          mis;
    bit          st;
    modelAccess(op, addr, wdata, rdw, rdata, e, expStrb, expWdata, mem, mis, st);
    sb.push_back(e);

    tbIf.ena           = 1'b1;
    tbIf.i_inst_opcode = op;
    tbIf.i_addr        = addr;
    tbIf.i_wdata       = wdata;
    tbIf.i_rd_wdata    = rdw;
    step();
    tbIf.ena = 1'b0;
    scrambleInputs();

    if (mem && !mis) begin
      for (int c = 0; c <= readyWait; c++) begin
        checkOutput("memValid", 64'(tbIf.o_mem_valid), 64'd1);
        checkOutput("memAddr", tbIf.o_mem_addr, {addr[63:3], 3'b000});
        checkOutput("memWen", 64'(tbIf.o_mem_wen), 64'(st));
        checkOutput("memWstrb", 64'(tbIf.o_mem_wstrb), 64'(expStrb));
        if (st) checkOutput("memWdata", tbIf.o_mem_wdata, expWdata);
        checkOutput("reqDuringBus", 64'(tbIf.req), 64'd0);
        if (c < readyWait) begin
          tbIf.i_mem_resp = (c == 0);
          step();
          tbIf.i_mem_resp = 1'b0;
        end
      end
      tbIf.i_mem_ready = 1'b1;
      step();
      tbIf.i_mem_ready = 1'b0;
      checkOutput("memValidDrop", 64'(tbIf.o_mem_valid), 64'd0);
      for (int c = 0; c < respWait; c++) begin
        checkOutput("reqBeforeResp", 64'(tbIf.req), 64'd0);
        step();
      end
      tbIf.i_mem_resp  = 1'b1;
      tbIf.i_mem_rdata = rdata;
      step();
      tbIf.i_mem_resp  = 1'b0;
      tbIf.i_mem_rdata = {$urandom, $urandom};
    end

    checkOutput("req", 64'(tbIf.req), 64'd1);
    checkOutput("memValidInDone", 64'(tbIf.o_mem_valid), 64'd0);
    if (tbIf.req === 1'b1 && sb.size() > 0) begin
      got = sb.pop_front();
      for (int c = 0; c <= ackWait; c++) begin
        checkOutput("rdWdata", tbIf.o_rd_wdata, got.res);
        checkOutput("misalign", 64'(tbIf.o_misalign), 64'(got.mis));
        checkOutput("reqHeld", 64'(tbIf.req), 64'd1);
        if (c < ackWait) begin
          tbIf.ena           = 1'b1;
          tbIf.i_inst_opcode = INST_LD;
          tbIf.i_addr        = 64'h0000_0000_0000_0040;
          step();
          tbIf.ena = 1'b0;
        end
      end
    end else begin
      checkOutput("scoreboardPop", 64'(sb.size()), 64'd1);
      sb.delete();
    end

    tbIf.ack = 1'b1;
    step();
    tbIf.ack = 1'b0;
    checkOutput("reqAfterAck", 64'(tbIf.req), 64'd0);
    step();
    checkOutput("idleReq", 64'(tbIf.req), 64'd0);
    checkOutput("idleValid", 64'(tbIf.o_mem_valid), 64'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_req"}, 64'(tbIf.req), 64'd0);
    checkOutput({tag, "_valid"}, 64'(tbIf.o_mem_valid), 64'd0);
    checkOutput({tag, "_wen"}, 64'(tbIf.o_mem_wen), 64'd0);
    checkOutput({tag, "_addr"}, tbIf.o_mem_addr, 64'd0);
    checkOutput({tag, "_wdata"}, tbIf.o_mem_wdata, 64'd0);
    checkOutput({tag, "_wstrb"}, 64'(tbIf.o_mem_wstrb), 64'd0);
    checkOutput({tag, "_rdWdata"}, tbIf.o_rd_wdata, 64'd0);
    checkOutput({tag, "_misalign"}, 64'(tbIf.o_misalign), 64'd0);
  endtask

  // Directed sequence of scenarios.
  initial begin
    nChecks = 0;
    nFail   = 0;
    rst = 1'b1;
    tbIf.ena = 1'b0;
    tbIf.ack = 1'b0;
    tbIf.i_mem_ready = 1'b0;
    tbIf.i_mem_resp  = 1'b0;
    tbIf.i_mem_rdata = 64'd0;
    scrambleInputs();
    step();
    step();
    checkAllZero("reset");
    rst = 1'b0;
    step();

    applyStimulus(INST_ADD, 64'h0, 64'h0, 64'h1234, 64'h0, 0, 0, 0);
    applyStimulus(INST_LB,  64'h8000_0003, 64'h0, 64'h5555, 64'h0000_0000_8000_0000, 0, 0, 0);
    applyStimulus(INST_LBU, 64'h8000_0003, 64'h0, 64'h5555, 64'h0000_0000_8000_0000, 0, 0, 0);
    applyStimulus(INST_SH,  64'h0000_1000_0000_0006, 64'hABCD, 64'h7777, 64'h0, 0, 1, 0);
    applyStimulus(INST_LW,  64'h0000_2000_0000_0002, 64'h0, 64'h9999, 64'h0, 0, 0, 0);
    applyStimulus(INST_SW,  64'h0000_0000_0000_0104, 64'hDEAD_BEEF, 64'h4242, 64'h0, 5, 2, 4);
    applyStimulus(INST_LH,  64'h0000_0000_0000_0202, 64'h0, 64'h0, 64'h1122_3344_F566_7788, 1, 0, 1);
    applyStimulus(INST_LHU, 64'h0000_0000_0000_0206, 64'h0, 64'h0, 64'hF122_3344_5566_7788, 0, 0, 0);
    applyStimulus(INST_LWU, 64'h0000_0000_0000_0304, 64'h0, 64'h0, 64'h8765_4321_0000_0000, 0, 3, 0);
    applyStimulus(INST_LW,  64'h0000_0000_0000_0304, 64'h0, 64'h0, 64'h8765_4321_0000_0000, 0, 0, 0);
    applyStimulus(INST_SB,  64'h0000_0000_0000_0407, 64'h0000_00A5, 64'h3131, 64'h0, 0, 0, 0);
    applyStimulus(INST_SD,  64'h0000_0000_0000_0500, 64'h0123_4567_89AB_CDEF, 64'h2020, 64'h0, 2, 0, 0);
    applyStimulus(INST_SD,  64'h0000_0000_0000_0504, 64'h1, 64'h6060, 64'h0, 0, 0, 2);
    applyStimulus(INST_LD,  64'h0000_0000_0000_0608, 64'h0, 64'h0, 64'hCAFE_F00D_1234_5678, 0, 0, 0);

    // Reset while the stage waits for a response, then a stray response.
    tbIf.ena           = 1'b1;
    tbIf.i_inst_opcode = INST_LD;
    tbIf.i_addr        = 64'h0000_0000_1000_0008;
    tbIf.i_rd_wdata    = 64'h1111;
    step();
    tbIf.ena = 1'b0;
    checkOutput("preResetValid", 64'(tbIf.o_mem_valid), 64'd1);
    tbIf.i_mem_ready = 1'b1;
    step();
    tbIf.i_mem_ready = 1'b0;
    rst = 1'b1;
    #2;
    checkAllZero("midReset");
    step();
    rst = 1'b0;
    tbIf.i_mem_resp  = 1'b1;
    tbIf.i_mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    step();
    tbIf.i_mem_resp = 1'b0;
    checkAllZero("lateResp");
    step();
    checkOutput("lateRespReq", 64'(tbIf.req), 64'd0);

    applyStimulus(INST_LD, 64'h0000_0000_1000_0010, 64'h0, 64'h0, 64'h0F0E_0D0C_0B0A_0908, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage placed directly after the execute stage. It takes the execute result and the load/store operands, performs at most one 64-bit-aligned data-bus transaction with byte-lane steering and load sign/zero extension, and presents the final `o_rd_wdata` to write-back. It uses the same `ena`/`req`/`ack` stage handshake as its neighbours.

## Interface
- No parameters. Opcode encodings are the `INST_*` macros from `defines.v`.
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `ena`  in  1  upstream holds valid operands. Sampled only in IDLE.
- `ack`  in  1  downstream accepted the result. Sampled only in DONE.
- `req`  out  1  result valid; held high until `ack`.
- `i_inst_opcode`  in  8  instruction opcode.
- `i_addr`  in  64  effective address (base + offset) for a load or store.
- `i_wdata`  in  64  store data (rs2).
- `i_rd_wdata`  in  64  execute result; passed through for non-memory opcodes.
- `o_mem_valid`  out  1  bus request valid.
- `i_mem_ready`  in  1  bus accepted the request.
- `o_mem_addr`  out  64  `{addr[63:3],3'b0}`.
- `o_mem_wen`  out  1  1 = store, 0 = load.
- `o_mem_wdata`  out  64  store data shifted into the addressed byte lanes.
- `o_mem_wstrb`  out  8  byte-lane enables; 0 for loads.
- `i_mem_resp`  in  1  response strobe: read data valid, or write complete.
- `i_mem_rdata`  in  64  aligned read doubleword.
- `o_rd_wdata`  out  64  final write-back value; valid while `req`=1.
- `o_misalign`  out  1  access was misaligned and no bus transaction was made; valid while `req`=1.

## Operation
- Memory opcodes:
  - Loads: LB, LH, LW, LD, LBU, LHU, LWU.
  - Stores: SB, SH, SW, SD.
  - Size is 1, 2, 4 or 8 bytes. An access is misaligned when `addr % size != 0`.
- On start (IDLE with `ena`=1), the block latches the opcode, address, wdata and rd_wdata. Inputs are don't-care after that point.
- States:
  - IDLE: `ena`=0 → stay in IDLE. Otherwise:
    - non-memory opcode or misaligned access → DONE;
    - aligned load/store → BUS_REQ.
  - BUS_REQ: `o_mem_valid`=1; all bus outputs are stable. `i_mem_ready`=1 → BUS_RESP.
  - BUS_RESP: `o_mem_valid`=0. `i_mem_resp`=1 → DONE; for a load, the extracted read data is captured on that same edge.
  - DONE: `req`=1. `ack`=1 → IDLE.
- Lane steering, with `off` = `addr[2:0]`:
  - `o_mem_wstrb` = `((1<<size)-1) << off`.
  - `o_mem_wdata` = `wdata << (8*off)`.
- Load data: `t = i_mem_rdata >> (8*off)`.
  - LB/LH/LW take `t[7:0]`, `t[15:0]`, `t[31:0]`, sign-extended.
  - LBU/LHU/LWU take the same fields, zero-extended.
  - LD takes `t`.
- Result in DONE:
  - load → extracted value;
  - store, misaligned access, or non-memory opcode → latched `i_rd_wdata`.
  - `o_misalign` = 1 only for a misaligned load/store.
- `i_mem_resp` outside BUS_RESP is ignored.
- `ena` in any state other than IDLE is ignored.

## Timing
- Reset values: state IDLE, and every output is 0 (`req`, `o_mem_valid`, `o_mem_wen`, `o_mem_addr`, `o_mem_wdata`, `o_mem_wstrb`, `o_rd_wdata`, `o_misalign`).
- All outputs are registered or decoded from registered state only. No combinational path runs from any input to `req` or `o_mem_valid`.
- Non-memory or misaligned access: `ena` in cycle 0 → `req`=1 in cycle 1.
- Aligned access:
  - `ena` in cycle 0 → `o_mem_valid`=1 from cycle 1.
  - `i_mem_ready` in cycle r → `o_mem_valid`=0 from cycle r+1.
  - `i_mem_resp` in cycle s ≥ r+1 → `req`=1 in cycle s+1.
  - Minimum latency is 3 cycles (ready in cycle 1, resp in cycle 2).
- `ack` in cycle a → `req`=0 in cycle a+1. A new `ena` is accepted no earlier than cycle a+1, so throughput is at most one access every 2 cycles.
- `req` stays high indefinitely while `ack`=0, and `o_rd_wdata` is stable throughout.
- Reset asserted mid-transaction (BUS_REQ or BUS_RESP) forces IDLE immediately. A late `i_mem_resp` arriving after reset is ignored.

## Test plan
- ADD passthrough: `i_rd_wdata`=0x1234, `ena` pulse → `req`=1 after 1 cycle, `o_rd_wdata`=0x1234, `o_mem_valid` never asserted.
- LB with sign extension: addr=0x8000_0003, rdata=0x0000_0000_8000_0000 → `o_mem_addr`=0x8000_0000, `wstrb`=0, result=0xFFFF_FFFF_FFFF_FF80. Same access as LBU → result=0x80.
- SH to addr 0x...06, wdata=0xABCD: → `wstrb`=0xC0, `wdata`=0xABCD_0000_0000_0000, `wen`=1; `req` one cycle after `i_mem_resp`, `o_rd_wdata`=`i_rd_wdata`.
- Misaligned LW at addr 0x...02: → no `o_mem_valid`, `req` in cycle 1, `o_misalign`=1.
- Back-pressure: `i_mem_ready` held low 5 cycles → `o_mem_valid` and the other bus outputs stay constant. Then `ack` held low 4 cycles in DONE → `req` and `o_rd_wdata` stay stable, and `ena` pulses during the wait are ignored (exactly one transaction occurs).
- Reset in BUS_RESP, then `i_mem_resp` pulse → all outputs 0, state IDLE, no `req`. The next LD completes normally.
